// File: rtl/mips_pkg.sv
// Shared MIPS definitions: instruction kinds, opcode/funct codes, loader FSM states.
// Used by the instruction encoder/loader and the control decoder.
package mips_pkg;

   typedef enum logic [3:0] {
      K_ADD  = 4'd0,
      K_SUB  = 4'd1,
      K_AND  = 4'd2,
      K_OR   = 4'd3,
      K_SLT  = 4'd4,
      K_LW   = 4'd5,
      K_SW   = 4'd6,
      K_BEQ  = 4'd7,
      K_J    = 4'd8,
      K_ANDI = 4'd9,
      K_ADDI = 4'd10,
      K_ORI  = 4'd11
   } instr_kind_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;

   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_SLT   = 6'b101010;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      FULL = 2'd2
   } state_t;

   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
      return {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] target);
      return {op, target};
   endfunction

endpackage

// File: rtl/instr_encode.sv
// Combinational MIPS instruction encoder: kind plus fields in, 32-bit word out.
// Kinds outside the defined set raise illegal and produce a zero word.
module instr_encode
   import mips_pkg::*;
(
   input  logic [3:0]  kind,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   output logic [31:0] word,
   output logic        illegal
);

   // Select layout and opcode/funct for the offered kind.
   always_comb begin
      word    = 32'd0;
      illegal = 1'b0;
      case (instr_kind_t'(kind))
         K_ADD:   word = enc_r(rs, rt, rd, FN_ADD);
         K_SUB:   word = enc_r(rs, rt, rd, FN_SUB);
         K_AND:   word = enc_r(rs, rt, rd, FN_AND);
         K_OR:    word = enc_r(rs, rt, rd, FN_OR);
         K_SLT:   word = enc_r(rs, rt, rd, FN_SLT);
         K_LW:    word = enc_i(OP_LW, rs, rt, imm);
         K_SW:    word = enc_i(OP_SW, rs, rt, imm);
         K_BEQ:   word = enc_i(OP_BEQ, rs, rt, imm);
         K_J:     word = enc_j(OP_J, target);
         K_ANDI:  word = enc_i(OP_ANDI, rs, rt, imm);
         K_ADDI:  word = enc_i(OP_ADDI, rs, rt, imm);
         K_ORI:   word = enc_i(OP_ORI, rs, rt, imm);
         default: begin
            word    = 32'd0;
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// Streams encoded MIPS instructions into instruction memory, one word per accept,
// with a registered write port and a bounded, non-wrapping write pointer.
module instr_encoder_loader
   import mips_pkg::*;
#(
   parameter  int DEPTH  = 256,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              finish,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_kind,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [15:0]       in_imm,
   input  logic [25:0]       in_target,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [ADDR_W:0]   word_count,
   output logic              busy,
   output logic              done,
   output logic              err_illegal
);

   localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [ADDR_W:0] ONE_CNT  = (ADDR_W+1)'(1);

   state_t      state;
   logic [31:0] enc_word;
   logic        enc_illegal;
   logic        accept_legal;

   instr_encode u_encode (
      .kind    (in_kind),
      .rs      (in_rs),
      .rt      (in_rt),
      .rd      (in_rd),
      .imm     (in_imm),
      .target  (in_target),
      .word    (enc_word),
      .illegal (enc_illegal)
   );

   assign accept_legal = in_valid && in_ready && !enc_illegal;

   // Loader FSM with registered write port, handshake and status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         in_ready    <= 1'b0;
         busy        <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= 32'd0;
         word_count  <= '0;
         done        <= 1'b0;
         err_illegal <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         done   <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state       <= LOAD;
                  in_ready    <= 1'b1;
                  busy        <= 1'b1;
                  word_count  <= '0;
                  err_illegal <= 1'b0;
               end
            end
            LOAD: begin
               if (in_valid && enc_illegal) begin
                  err_illegal <= 1'b1;
               end
               if (accept_legal) begin
                  mem_we     <= 1'b1;
                  mem_addr   <= word_count[ADDR_W-1:0];
                  mem_wdata  <= enc_word;
                  word_count <= word_count + ONE_CNT;
               end
               // finish wins over filling up; the final write still lands with done
               if (finish) begin
                  state    <= IDLE;
                  in_ready <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
               end else if (accept_legal && (word_count == LAST_CNT)) begin
                  state    <= FULL;
                  in_ready <= 1'b0;
               end
            end
            FULL: begin
               if (finish) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench: driver updates a behavioural model and queues expected writes;
// a negedge monitor compares every output against the model.
module tb_instr_encoder_loader;

   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          finish = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [3:0]    in_kind = 4'd0;
   logic [4:0]    in_rs = 5'd0;
   logic [4:0]    in_rt = 5'd0;
   logic [4:0]    in_rd = 5'd0;
   logic [15:0]   in_imm = 16'd0;
   logic [25:0]   in_target = 26'd0;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [AW:0]   word_count;
   logic          busy;
   logic          done;
   logic          err_illegal;

   instr_encoder_loader #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .start(start), .finish(finish),
      .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
      .in_target(in_target), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .word_count(word_count), .busy(busy),
      .done(done), .err_illegal(err_illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   wr_t exp_q[$];
   int  checks = 0;
   int  failures = 0;
   // model: 0 = idle, 1 = loading, 2 = memory full
   int  mstate = 0;
   int  mcount = 0;
   bit  merr = 1'b0;
   bit  mdone = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [31:0] ref_word(input int k, input int rs, input int rt,
                                            input int rd, input int imm, input int tgt);
      longint op_tab[12];
      longint fn_tab[5];
      longint w;
      op_tab = '{0, 0, 0, 0, 0, 35, 43, 4, 2, 12, 8, 13};
      fn_tab = '{32, 34, 36, 37, 42};
      if (k < 5)
         w = rs * 64'd2097152 + rt * 64'd65536 + rd * 64'd2048 + fn_tab[k];
      else if (k == 8)
         w = op_tab[k] * 64'd67108864 + tgt;
      else
         w = op_tab[k] * 64'd67108864 + rs * 64'd2097152 + rt * 64'd65536 + imm;
      return w[31:0];
   endfunction

   task automatic model_update();
      mdone = 1'b0;
      if (reset) begin
         mstate = 0;
         mcount = 0;
         merr   = 1'b0;
      end else if (mstate == 0) begin
         if (start) begin
            mstate = 1;
            mcount = 0;
            merr   = 1'b0;
         end
      end else if (mstate == 1) begin
         if (in_valid) begin
            if (int'(in_kind) < 12) begin
               exp_q.push_back('{AW'(mcount),
                  ref_word(int'(in_kind), int'(in_rs), int'(in_rt), int'(in_rd),
                           int'(in_imm), int'(in_target))});
               mcount++;
            end else begin
               merr = 1'b1;
            end
         end
         if (finish) begin
            mstate = 0;
            mdone  = 1'b1;
         end else if (mcount == DEPTH) begin
            mstate = 2;
         end
      end else begin
         if (finish) begin
            mstate = 0;
            mdone  = 1'b1;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic offer(input int k, input int rs, input int rt, input int rd,
                        input int imm, input int tgt, input bit fin);
      in_kind   = 4'(k);
      in_rs     = 5'(rs);
      in_rt     = 5'(rt);
      in_rd     = 5'(rd);
      in_imm    = 16'(imm);
      in_target = 26'(tgt);
      in_valid  = 1'b1;
      finish    = fin;
      step();
      in_valid  = 1'b0;
      finish    = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic do_finish();
      finish = 1'b1;
      step();
      finish = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_mem_we"}, mem_we, 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_mem_wdata"}, mem_wdata, 0);
      chk({tag, "_word_count"}, word_count, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err_illegal, 0);
   endtask

   // Monitor: compares every output with the model and pops expected writes.
   always @(negedge clk) begin
      chk("in_ready", in_ready, 64'(mstate == 1));
      chk("busy", busy, 64'(mstate != 0));
      chk("done", done, 64'(mdone));
      chk("word_count", word_count, 64'(mcount));
      chk("err_illegal", err_illegal, 64'(merr));
      chk("mem_we", mem_we, 64'(exp_q.size() > 0));
      if (mem_we && exp_q.size() > 0) begin
         wr_t e;
         e = exp_q.pop_front();
         chk("mem_addr", mem_addr, e.addr);
         chk("mem_wdata", mem_wdata, e.data);
      end
   end

   initial begin
      bit held;
      // reference encodings of the documented example words
      chk("ref_add", ref_word(0, 1, 2, 3, 0, 0), 32'h00221820);
      chk("ref_lw", ref_word(5, 29, 8, 0, 4, 0), 32'h8FA80004);
      chk("ref_beq", ref_word(7, 4, 5, 0, 16'hFFFF, 0), 32'h1085FFFF);
      chk("ref_j", ref_word(8, 0, 0, 0, 0, 26'h10), 32'h08000010);
      chk("ref_ori", ref_word(11, 0, 9, 0, 16'h00FF, 0), 32'h340900FF);
      chk("ref_sw", ref_word(6, 2, 3, 0, 8, 0), 32'hAC430008);

      step();
      step();
      reset = 1'b0;
      chk_zero("reset");

      // single ADD
      do_start();
      offer(0, 1, 2, 3, 0, 0, 1'b0);
      chk("add_addr0", mem_addr, 0);
      do_finish();

      // back-to-back LW, BEQ, J
      do_start();
      offer(5, 29, 8, 0, 4, 0, 1'b0);
      offer(7, 4, 5, 0, 16'hFFFF, 0, 1'b0);
      offer(8, 0, 0, 0, 0, 26'h10, 1'b0);
      chk("b2b_count", word_count, 3);
      do_finish();
      step();
      chk("idle_hold_count", word_count, 3);

      // illegal kind then ORI
      do_start();
      offer(14, 1, 1, 1, 1, 1, 1'b0);
      chk("illegal_no_write", mem_we, 0);
      chk("illegal_flag", err_illegal, 1);
      offer(11, 0, 9, 0, 16'h00FF, 0, 1'b0);
      chk("ori_addr0", mem_addr, 0);
      do_finish();

      // fill to DEPTH, excess offers refused
      do_start();
      for (int i = 0; i < 6; i++) offer(10, i, i + 1, 0, i * 3, 0, 1'b0);
      chk("full_ready", in_ready, 0);
      chk("full_count", word_count, DEPTH);
      do_finish();
      chk("full_done", done, 1);
      chk("full_count_after", word_count, DEPTH);

      // finish together with an accept
      do_start();
      offer(6, 2, 3, 0, 8, 0, 1'b1);
      chk("fin_done", done, 1);
      chk("fin_busy", busy, 0);

      // reset with a pending accept
      do_start();
      offer(0, 4, 5, 6, 0, 0, 1'b0);
      reset = 1'b1;
      offer(1, 7, 8, 9, 0, 0, 1'b0);
      reset = 1'b0;
      chk_zero("midreset");
      do_start();
      offer(3, 1, 1, 1, 0, 0, 1'b0);
      chk("restart_addr0", mem_addr, 0);
      do_finish();

      // randomized traffic
      held = 1'b0;
      for (int c = 0; c < 400; c++) begin
         reset  = ($urandom_range(0, 99) == 0);
         start  = ($urandom_range(0, 7) == 0);
         finish = ($urandom_range(0, 11) == 0);
         if (!held) begin
            in_valid  = $urandom_range(0, 2) != 0;
            in_kind   = ($urandom_range(0, 9) == 0) ? 4'(12 + $urandom_range(0, 3))
                                                    : 4'($urandom_range(0, 11));
            in_rs     = 5'($urandom);
            in_rt     = 5'($urandom);
            in_rd     = 5'($urandom);
            in_imm    = 16'($urandom);
            in_target = 26'($urandom);
         end
         held = in_valid && (mstate != 1) && !reset;
         step();
      end
      reset    = 1'b0;
      start    = 1'b0;
      finish   = 1'b0;
      in_valid = 1'b0;
      step();
      step();
      chk("queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
